// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer owns the master side: it takes status in and drives selects and strobes out.
interface multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 32,
    parameter int STATE_W   = 4
);
    logic                 run;
    logic [5:0]           opcode;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 ir_write;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic [1:0]           pc_source;
    logic                 illegal_op;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [STATE_W-1:0]   state;

    modport master (
        input  run, opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count, state
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, instr_count, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps one shared memory port, ALU and adder
// through fetch/decode/execute states, stalling in memory states until mem_ready.
module multicycle_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int STATE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t               state_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 retire_s;

    logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
    logic       ir_write_s, mem_to_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
    logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;
    logic       illegal_op_s;

    // Last cycle of an instruction: the edge leaving this state retires it.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire_s = 1'b1;
            S_MEMWR:                                     retire_s = bus.mem_ready;
            default:                                     retire_s = 1'b0;
        endcase
    end

    // Sequencer state and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
            count_r <= '0;
        end else begin
            if (retire_s) begin
                count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
            case (state_r)
                S_FETCH: begin
                    if (bus.run && bus.mem_ready) state_r <= S_DECODE;
                    else                          state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:     state_r <= S_EXEC;
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_J:         state_r <= S_JUMP;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        default:      state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (bus.opcode == OP_SW) state_r <= S_MEMWR;
                    else                     state_r <= S_MEMRD;
                end
                S_MEMRD: begin
                    if (bus.mem_ready) state_r <= S_MEMWB;
                    else               state_r <= S_MEMRD;
                end
                S_MEMWR: begin
                    if (bus.mem_ready) state_r <= S_FETCH;
                    else               state_r <= S_MEMWR;
                end
                S_EXEC:   state_r <= S_RWB;
                S_ADDIEX: state_r <= S_ADDIWB;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Per-state control word; undecoded encodings leave everything at 0.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        illegal_op_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = bus.run;
                alu_src_b_s = 2'b01;
                ir_write_s  = bus.run & bus.mem_ready;
                pc_write_s  = bus.run & bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (bus.opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op_s = 1'b0;
                    default:                                       illegal_op_s = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                i_or_d_s    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_RWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            default:  illegal_op_s = 1'b0;
        endcase
    end

    // Strobes are masked by rst so a fetch held in reset never loads IR or PC.
    assign bus.pc_write      = pc_write_s      & ~rst;
    assign bus.pc_write_cond = pc_write_cond_s & ~rst;
    assign bus.mem_write     = mem_write_s     & ~rst;
    assign bus.ir_write      = ir_write_s      & ~rst;
    assign bus.reg_write     = reg_write_s     & ~rst;
    assign bus.i_or_d        = i_or_d_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.pc_source     = pc_source_s;
    assign bus.illegal_op    = illegal_op_s;
    assign bus.instr_count   = count_r;
    assign bus.state         = STATE_W'(state_r);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected cycle list; a negedge process compares every cycle.
module tb_multicycle_ctrl;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        logic       run;
        logic       mr;
        logic [5:0] op;
        logic       ret;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_WIDTH(32), .STATE_W(4)) bus ();
    multicycle_ctrl_if #(.CNT_WIDTH(4),  .STATE_W(4)) bus4 ();
    assign bus4.run       = bus.run;
    assign bus4.opcode    = bus.opcode;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    multicycle_ctrl #(.CNT_WIDTH(32), .STATE_W(4)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
    multicycle_ctrl #(.CNT_WIDTH(4),  .STATE_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));

    int          checks = 0;
    int          errors = 0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_state = 4'd0;
    logic [31:0] exp_count = 32'd0;
    logic [31:0] model_cnt = 32'd0;
    cyc_t        q[$];
    ctl_t        act;

    assign act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                  bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, a, e, $time);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic r, input logic mr,
                                     input logic [5:0] op, input logic rs);
        ctl_t c;
        c = '0;
        case (st)
            4'd0: begin
                c.mem_read = r; c.alu_src_b = 2'b01;
                c.ir_write = r & mr; c.pc_write = r & mr;
            end
            4'd1:  begin c.alu_src_b = 2'b11; c.illegal_op = ~is_legal(op); end
            4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            4'd5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
            4'd9:  begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            4'd10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            4'd11: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        if (rs) begin
            c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.mem_write = 1'b0;
            c.ir_write = 1'b0; c.reg_write = 1'b0;
        end
        return c;
    endfunction

    // Single per-cycle compare of both DUTs against the model's expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("state", 32'(bus.state), 32'(exp_state));
            check("ctl", 32'(act), 32'(exp_ctl(exp_state, bus.run, bus.mem_ready, bus.opcode, rst)));
            check("count", bus.instr_count, exp_count);
            check("count4", 32'(bus4.instr_count), 32'(exp_count[3:0]));
            check("state4", 32'(bus4.state), 32'(exp_state));
        end
    end

    task automatic push(input logic [3:0] st, input logic r, input logic mr,
                        input logic [5:0] op, input logic ret);
        cyc_t c;
        c.st = st; c.run = r; c.mr = mr; c.op = op; c.ret = ret;
        q.push_back(c);
    endtask

    task automatic drive_cycle(input cyc_t c);
        @(posedge clk);
        #1;
        bus.run       = c.run;
        bus.mem_ready = c.mr;
        bus.opcode    = c.op;
        bus.zero      = 1'($urandom);
        exp_state     = c.st;
        exp_count     = model_cnt;
        exp_valid     = 1'b1;
        if (c.ret) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic drive_all(output int n);
        n = 0;
        while (q.size() > 0) begin
            drive_cycle(q.pop_front());
            n++;
        end
    endtask

    // Expand one instruction into the cycles it must take for the chosen wait pattern.
    task automatic plan_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(4'd0, 1'b1, 1'b0, 6'($urandom), 1'b0);
        push(4'd0, 1'b1, 1'b1, 6'($urandom), 1'b0);
        push(4'd1, 1'b1, 1'($urandom), op, 1'b0);
        case (op)
            OP_RTYPE: begin push(4'd6, 1'b1, 1'($urandom), op, 1'b0); push(4'd7, 1'b1, 1'($urandom), op, 1'b1); end
            OP_LW: begin
                push(4'd2, 1'b1, 1'($urandom), op, 1'b0);
                for (int i = 0; i < mw; i++) push(4'd3, 1'b1, 1'b0, op, 1'b0);
                push(4'd3, 1'b1, 1'b1, op, 1'b0);
                push(4'd4, 1'b1, 1'($urandom), op, 1'b1);
            end
            OP_SW: begin
                push(4'd2, 1'b1, 1'($urandom), op, 1'b0);
                for (int i = 0; i < mw; i++) push(4'd5, 1'b1, 1'b0, op, 1'b0);
                push(4'd5, 1'b1, 1'b1, op, 1'b1);
            end
            OP_BEQ:  push(4'd8, 1'b1, 1'($urandom), op, 1'b1);
            OP_J:    push(4'd9, 1'b1, 1'($urandom), op, 1'b1);
            OP_ADDI: begin push(4'd10, 1'b1, 1'($urandom), op, 1'b0); push(4'd11, 1'b1, 1'($urandom), op, 1'b1); end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, output int n);
        plan_instr(op, fw, mw);
        drive_all(n);
    endtask

    task automatic idle(input int k);
        int n;
        for (int i = 0; i < k; i++) push(4'd0, 1'b0, 1'($urandom), 6'($urandom), 1'b0);
        drive_all(n);
    endtask

    task automatic hold_reset(input logic r, input int k);
        int n;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_cnt = 32'd0;
        for (int i = 0; i < k; i++) push(4'd0, r, 1'b1, 6'($urandom), 1'b0);
        drive_all(n);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.run = 1'b0;
        exp_state = 4'd0;
        exp_count = model_cnt;
    endtask

    initial begin
        int n;
        logic [5:0] op;
        logic [5:0] ops [6];
        ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ;   ops[4] = OP_J;  ops[5] = OP_ADDI;
        bus.run = 1'b0; bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        hold_reset(1'b0, 2);
        release_reset();
        idle(10);
        #1;
        check("idle_state", 32'(bus.state), 32'd0);
        check("idle_mem_read", 32'(bus.mem_read), 32'd0);
        check("idle_count", bus.instr_count, 32'd0);

        hold_reset(1'b1, 3);
        check("rst_run_mem_read", 32'(bus.mem_read), 32'd1);
        check("rst_run_ir_write", 32'(bus.ir_write), 32'd0);
        check("rst_run_pc_write", 32'(bus.pc_write), 32'd0);
        release_reset();

        run_instr(OP_RTYPE, 0, 0, n); check("rtype_cycles", n, 32'd4);
        idle(1); check("rtype_count", bus.instr_count, 32'd1);
        run_instr(OP_LW, 0, 3, n);    check("lw_wait3_cycles", n, 32'd8);
        run_instr(OP_BEQ, 0, 0, n);   check("beq_cycles_a", n, 32'd3);
        run_instr(OP_BEQ, 0, 0, n);   check("beq_cycles_b", n, 32'd3);
        run_instr(6'b111111, 0, 0, n); check("illegal_cycles", n, 32'd2);
        idle(1); check("illegal_count", bus.instr_count, 32'd4);
        run_instr(OP_J, 0, 0, n);     check("j_cycles", n, 32'd3);
        idle(1); check("j_count", bus.instr_count, 32'd5);
        run_instr(OP_SW, 0, 0, n);    check("sw_cycles", n, 32'd4);
        run_instr(OP_ADDI, 0, 0, n);  check("addi_cycles", n, 32'd4);
        run_instr(OP_LW, 0, 0, n);    check("lw_cycles", n, 32'd5);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), n);
            idle($urandom_range(0, 2));
        end

        // Async reset while a store is stalled waiting for memory.
        push(4'd0, 1'b1, 1'b1, 6'($urandom), 1'b0);
        push(4'd1, 1'b1, 1'b0, OP_SW, 1'b0);
        push(4'd2, 1'b1, 1'b0, OP_SW, 1'b0);
        push(4'd5, 1'b1, 1'b0, OP_SW, 1'b0);
        drive_all(n);
        #2;
        check("memwr_state", 32'(bus.state), 32'd5);
        check("memwr_mem_write", 32'(bus.mem_write), 32'd1);
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_state", 32'(bus.state), 32'd0);
        check("async_mem_write", 32'(bus.mem_write), 32'd0);
        check("async_count", bus.instr_count, 32'd0);
        model_cnt = 32'd0;
        release_reset();
        exp_valid = 1'b1;
        idle(2);

        hold_reset(1'b0, 1);
        release_reset();
        for (int i = 0; i < 16; i++) run_instr(OP_ADDI, 0, 0, n);
        idle(1);
        check("wrap_count4", 32'(bus4.instr_count), 32'd0);
        check("wrap_count32", bus.instr_count, 32'd16);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
